// File: rtl/rocketcpu_pkg.sv
// Shared types and defaults for the RocketCPU audio parameter bus arbiter.
package rocketcpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS0 = 2'd1,
      ST_BUS1 = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int          TIMEOUT_CYCLES_DEF = 255;
   localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

endpackage

// File: rtl/rocketcpu_audio_arbiter_if.sv
// One Wishbone-style bus leg: a master drives the request, a slave answers.
interface rocketcpu_audio_arbiter_if;
   logic [31:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic [31:0] rdt;
   logic        ack;

   modport master (output adr, dat, sel, we, cyc, input  rdt, ack);
   modport slave  (input  adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/rocketcpu_rr_pick.sv
// Two-way round-robin selector: a lone request wins, a tie goes to i_prio.
module rocketcpu_rr_pick (
   input  logic [1:0] i_req,
   input  logic       i_prio,
   output logic       o_vld,
   output logic       o_gnt
);

   assign o_vld = |i_req;
   assign o_gnt = (i_req == 2'b11) ? i_prio : i_req[1];

endmodule

// File: rtl/rocketcpu_audio_arbiter.sv
// Arbitrates CPU and preset loader onto the audio parameter register bank,
// with a slave wait timeout that completes the transfer with ERR_DATA.
module rocketcpu_audio_arbiter
   import rocketcpu_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
   input  logic        i_wb_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   input  logic [3:0]  i_m0_sel,
   input  logic        i_m0_we,
   input  logic        i_m0_cyc,
   output logic [31:0] o_m0_rdt,
   output logic        o_m0_ack,
   input  logic [31:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   input  logic [3:0]  i_m1_sel,
   input  logic        i_m1_we,
   input  logic        i_m1_cyc,
   output logic [31:0] o_m1_rdt,
   output logic        o_m1_ack,
   output logic [31:0] o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic        o_s_we,
   output logic        o_s_cyc,
   input  logic [31:0] i_s_rdt,
   input  logic        i_s_ack,
   output logic        o_timeout
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t          r_state;
   logic            r_prio;
   logic [CW-1:0]   r_wait;
   logic            w_bus, w_g, w_cyc_g, w_expired, w_to, w_ack;
   logic            w_pick_vld, w_pick;
   logic [31:0]     w_rdt;

   rocketcpu_rr_pick u_pick (
      .i_req  ({i_m1_cyc, i_m0_cyc}),
      .i_prio (r_prio),
      .o_vld  (w_pick_vld),
      .o_gnt  (w_pick)
   );

   assign w_bus     = (r_state == ST_BUS0) || (r_state == ST_BUS1);
   assign w_g       = (r_state == ST_BUS1);
   assign w_cyc_g   = w_g ? i_m1_cyc : i_m0_cyc;
   assign w_expired = (r_wait == CW'(TIMEOUT_CYCLES));
   // A slave ack on the expiry cycle wins; the timeout only fires without one.
   assign w_to      = w_bus && w_cyc_g && !i_s_ack && w_expired;
   assign w_ack     = w_bus && w_cyc_g && (i_s_ack || w_expired);
   assign w_rdt     = i_s_ack ? i_s_rdt : ERR_DATA;

   assign o_m0_ack  = w_ack && !w_g;
   assign o_m1_ack  = w_ack && w_g;
   assign o_m0_rdt  = o_m0_ack ? w_rdt : 32'h0;
   assign o_m1_rdt  = o_m1_ack ? w_rdt : 32'h0;
   assign o_timeout = w_to;

   assign o_s_cyc = w_bus;
   assign o_s_we  = w_bus && (w_g ? i_m1_we : i_m0_we);
   assign o_s_adr = !w_bus ? 32'h0 : (w_g ? i_m1_adr : i_m0_adr);
   assign o_s_dat = !w_bus ? 32'h0 : (w_g ? i_m1_dat : i_m0_dat);
   assign o_s_sel = !w_bus ? 4'h0  : (w_g ? i_m1_sel : i_m0_sel);

   always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_prio  <= 1'b0;
         r_wait  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_state <= w_pick ? ST_BUS1 : ST_BUS0;
                  r_prio  <= ~w_pick;
                  r_wait  <= '0;
               end
            end
            ST_BUS0, ST_BUS1: begin
               // Dropped cyc abandons the transfer without an ack.
               if (!w_cyc_g || w_ack) r_state <= ST_DONE;
               else                   r_wait  <= r_wait + CW'(1);
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rocketcpu_audio_arbiter.sv
// Randomized and directed bench for the audio arbiter against a transaction-level model.
module tb_rocketcpu_audio_arbiter;

   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam logic [31:0] XK  = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic w_timeout;

   rocketcpu_audio_arbiter_if m0 ();
   rocketcpu_audio_arbiter_if m1 ();
   rocketcpu_audio_arbiter_if s ();

   always #5 clk = ~clk;

   rocketcpu_audio_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
      .i_wb_clk (clk),     .i_rst_n  (rst_n),
      .i_m0_adr (m0.adr),  .i_m0_dat (m0.dat), .i_m0_sel (m0.sel),
      .i_m0_we  (m0.we),   .i_m0_cyc (m0.cyc), .o_m0_rdt (m0.rdt), .o_m0_ack (m0.ack),
      .i_m1_adr (m1.adr),  .i_m1_dat (m1.dat), .i_m1_sel (m1.sel),
      .i_m1_we  (m1.we),   .i_m1_cyc (m1.cyc), .o_m1_rdt (m1.rdt), .o_m1_ack (m1.ack),
      .o_s_adr  (s.adr),   .o_s_dat  (s.dat),  .o_s_sel  (s.sel),
      .o_s_we   (s.we),    .o_s_cyc  (s.cyc),  .i_s_rdt  (s.rdt),  .i_s_ack  (s.ack),
      .o_timeout(w_timeout)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Transaction-level model: who owns the bus, how long it has waited,
   // whether we are in the post-transfer rest cycle, and who won last.
   int own = -1, waited = 0, last = 1;
   bit rest = 0;
   int lat = 0;          // directed slave: ack on this bus cycle (0 = never)
   bit rnd_slave = 0;
   bit g_ack0, g_ack1;
   int ack_log[$];
   logic [31:0] rdt_log[$];
   int ack_cyc[$];
   int cyc_hi = 0, to_cnt = 0, cyc_n = 0;

   function automatic logic [31:0] f_adr(input int i); return (i == 1) ? m1.adr : m0.adr; endfunction
   function automatic logic [31:0] f_dat(input int i); return (i == 1) ? m1.dat : m0.dat; endfunction
   function automatic logic [4:0]  f_ctl(input int i);
      return (i == 1) ? {m1.we, m1.sel} : {m0.we, m0.sel};
   endfunction

   task automatic model_reset();
      own = -1; waited = 0; last = 1; rest = 0;
   endtask

   task automatic clr_logs();
      ack_log.delete(); rdt_log.delete(); ack_cyc.delete();
      cyc_hi = 0; to_cnt = 0;
   endtask

   task automatic set_m(input int i, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
      if (i == 1) begin m1.we = we; m1.adr = adr; m1.dat = dat; m1.sel = sel; m1.cyc = 1'b1; end
      else        begin m0.we = we; m0.adr = adr; m0.dat = dat; m0.sel = sel; m0.cyc = 1'b1; end
   endtask

   // One clock: drive slave, check outputs mid-cycle, advance model at the edge.
   task automatic step();
      bit c0, c1, co, hit, eto;
      logic [31:0] er;
      if (rnd_slave) s.ack = ($urandom_range(0, 3) == 0);
      else           s.ack = (own >= 0) && (lat != 0) && (waited + 1 == lat);
      s.rdt = rnd_slave ? 32'($urandom) : ((own >= 0 ? f_adr(own) : 32'h0) ^ XK);
      #1;
      c0  = m0.cyc; c1 = m1.cyc;
      co  = (own == 0) ? c0 : (own == 1) ? c1 : 1'b0;
      hit = co && (s.ack || waited == TO);
      eto = co && !s.ack && waited == TO;
      er  = s.ack ? s.rdt : ERR;
      chk("s_cyc",   32'(s.cyc), 32'(own >= 0));
      chk("s_adr",   s.adr, own >= 0 ? f_adr(own) : 32'h0);
      chk("s_dat",   s.dat, own >= 0 ? f_dat(own) : 32'h0);
      chk("s_ctl",   32'({s.we, s.sel}), own >= 0 ? 32'(f_ctl(own)) : 32'h0);
      chk("m0_ack",  32'(m0.ack), 32'(hit && own == 0));
      chk("m0_rdt",  m0.rdt, (hit && own == 0) ? er : 32'h0);
      chk("m1_ack",  32'(m1.ack), 32'(hit && own == 1));
      chk("m1_rdt",  m1.rdt, (hit && own == 1) ? er : 32'h0);
      chk("timeout", 32'(w_timeout), 32'(eto));
      g_ack0 = m0.ack; g_ack1 = m1.ack;
      if (m0.ack) begin ack_log.push_back(0); rdt_log.push_back(m0.rdt); ack_cyc.push_back(cyc_n); end
      if (m1.ack) begin ack_log.push_back(1); rdt_log.push_back(m1.rdt); ack_cyc.push_back(cyc_n); end
      if (s.cyc) cyc_hi++;
      if (w_timeout) to_cnt++;
      cyc_n++;
      @(posedge clk);
      if (own >= 0) begin
         if (!co || hit) begin own = -1; rest = 1; end
         else waited++;
      end else if (rest) rest = 0;
      else if (c0 || c1) begin
         own = (c0 && c1) ? 1 - last : (c1 ? 1 : 0);
         last = own; waited = 0;
      end
      @(negedge clk);
   endtask

   task automatic run_until(input int n, input int bound, input bit autodrop);
      int k;
      for (k = 0; k < bound; k++) begin
         step();
         if (autodrop && g_ack0) m0.cyc = 1'b0;
         if (autodrop && g_ack1) m1.cyc = 1'b0;
         if (ack_log.size() >= n) break;
      end
      if (k == bound) chk("ack_wait_bound", 32'(ack_log.size()), 32'(n));
   endtask

   task automatic settle();
      m0.cyc = 1'b0; m1.cyc = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      m0.cyc = 1'b0; m1.cyc = 1'b0;
      set_m(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
      set_m(1, 1'b0, 32'h1000_0008, 32'h0, 4'hF);
      s.ack = 1'b1; s.rdt = 32'h1234_5678;
      #2;
      chk("rst_s_cyc",  32'(s.cyc), 32'h0);
      chk("rst_s_adr",  s.adr, 32'h0);
      chk("rst_acks",   32'({m0.ack, m1.ack, w_timeout}), 32'h0);
      chk("rst_rdt",    m0.rdt | m1.rdt, 32'h0);

      // Simultaneous requests out of reset: master 0 first, then master 1.
      @(negedge clk); rst_n = 1'b1;
      model_reset(); clr_logs(); lat = 2;
      run_until(2, 30, 1'b1);
      chk("tie_first",  32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'h0);
      chk("tie_second", 32'(ack_log.size() > 1 ? ack_log[1] : -1), 32'h1);
      chk("tie_rdt0",   rdt_log.size() > 0 ? rdt_log[0] : 32'hX, 32'h1000_0000 ^ XK);
      chk("tie_rdt1",   rdt_log.size() > 1 ? rdt_log[1] : 32'hX, 32'h1000_0008 ^ XK);
      chk("tie_gap",    32'(ack_cyc.size() > 1 ? ack_cyc[1] - ack_cyc[0] : -1), 32'd4);

      // Single write from master 0, slave acks on second bus cycle.
      settle(); clr_logs();
      set_m(0, 1'b1, 32'h1000_0004, 32'h0000_1234, 4'hF);
      lat = 2;
      run_until(1, 10, 1'b1);
      repeat (2) step();
      chk("wr_cyc_hi",  32'(cyc_hi), 32'd2);
      chk("wr_acks",    32'(ack_log.size()), 32'd1);
      chk("wr_who",     32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'h0);

      // Master 1 with a silent slave: timeout completion.
      settle(); clr_logs();
      set_m(1, 1'b0, 32'h1000_000C, 32'h0, 4'h3);
      lat = 0;
      run_until(1, 20, 1'b1);
      repeat (2) step();
      chk("to_who",     32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'h1);
      chk("to_rdt",     rdt_log.size() > 0 ? rdt_log[0] : 32'hX, ERR);
      chk("to_pulses",  32'(to_cnt), 32'd1);
      chk("to_cyc_hi",  32'(cyc_hi), 32'(TO + 1));

      // Both masters hold requests: grants alternate starting with master 0.
      settle(); clr_logs();
      set_m(0, 1'b0, 32'h1000_0020, 32'h0, 4'hF);
      set_m(1, 1'b1, 32'h1000_0024, 32'hCAFE_0001, 4'hC);
      lat = 1;
      run_until(6, 40, 1'b0);
      for (int i = 0; i < 6; i++)
         chk($sformatf("alt_%0d", i), 32'(ack_log.size() > i ? ack_log[i] : -1), 32'(i % 2));

      // Slave ack on the exact timeout cycle is a normal completion.
      settle(); clr_logs();
      set_m(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
      lat = TO + 1;
      run_until(1, 20, 1'b1);
      chk("edge_to",    32'(to_cnt), 32'h0);
      chk("edge_rdt",   rdt_log.size() > 0 ? rdt_log[0] : 32'hX, 32'h1000_0010 ^ XK);
      chk("edge_cycs",  32'(cyc_hi), 32'(TO + 1));

      // Reset pulse during a master 1 transfer.
      settle();
      set_m(1, 1'b0, 32'h1000_0030, 32'h0, 4'hF);
      lat = 0;
      step(); step();
      chk("pre_rst_own", 32'(own), 32'h1);
      set_m(0, 1'b0, 32'h1000_0034, 32'h0, 4'hF);
      s.ack = 1'b1; s.rdt = 32'h0BAD_F00D;
      #1;
      chk("pre_rst_ack",  32'({s.cyc, m1.ack}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_cyc",  32'(s.cyc), 32'h0);
      chk("rst_mid_ack",  32'({m1.ack, m0.ack}), 32'h0);
      chk("rst_mid_rdt",  m1.rdt, 32'h0);
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      clr_logs(); lat = 1;
      run_until(2, 20, 1'b1);
      chk("post_rst_first", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'h0);

      // Random traffic against the model.
      settle(); clr_logs();
      rnd_slave = 1'b1;
      for (int n = 0; n < 400; n++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            bit c, a;
            c = (i == 1) ? m1.cyc : m0.cyc;
            a = (i == 1) ? g_ack1 : g_ack0;
            if (c && a) begin
               if ($urandom_range(0, 1) == 0) begin
                  if (i == 1) m1.cyc = 1'b0; else m0.cyc = 1'b0;
               end
            end else if (c) begin
               if ($urandom_range(0, 19) == 0) begin
                  if (i == 1) m1.cyc = 1'b0; else m0.cyc = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0)
               set_m(i, 1'($urandom), 32'($urandom), 32'($urandom), 4'($urandom));
         end
      end
      chk("rnd_progress", 32'(ack_log.size() > 20), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rocketcpu_audio_arbiter.md
ROCKETCPU_AUDIO_ARBITER -- requirements
Module: rocketcpu_audio_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum slave wait cycles before a forced error completion.
REQ-002 The block SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, meaning the read data returned on timeout.
REQ-003 i_wb_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_m0_adr, i_m0_dat  input  32 each  master 0 (CPU) address and write data.
REQ-006 i_m0_sel  input  4;  i_m0_we, i_m0_cyc  input  1 each  master 0 byte select, write enable, cycle request.
REQ-007 o_m0_rdt  output  32;  o_m0_ack  output  1  master 0 read data and acknowledge.
REQ-008 i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc, o_m1_rdt, o_m1_ack  same widths  master 1 (preset loader) port, identical semantics.
REQ-009 o_s_adr, o_s_dat  output  32;  o_s_sel  output  4;  o_s_we, o_s_cyc  output  1  slave (audio parameter register bank) port.
REQ-010 i_s_rdt  input  32;  i_s_ack  input  1  slave read data and acknowledge.
REQ-011 o_timeout  output  1  one-cycle pulse on a timeout completion.

Function
REQ-012 The FSM SHALL have states IDLE, BUS0, BUS1, DONE.
REQ-013 In IDLE with exactly one i_mN_cyc high, the FSM SHALL enter BUSN on the next edge.
REQ-014 In IDLE with both requests high, the FSM SHALL grant the master not granted last (round-robin pointer); after reset the pointer SHALL favour master 0.
REQ-015 The round-robin pointer SHALL update only on entry to BUS0/BUS1.
REQ-016 In BUSN, o_s_adr/dat/sel/we SHALL combinationally mirror master N, and o_s_cyc SHALL be 1.
REQ-017 Outside BUS0/BUS1, o_s_cyc, o_s_we, o_s_adr, o_s_dat and o_s_sel SHALL all be 0.
REQ-018 In BUSN with i_s_ack high, o_mN_ack SHALL be 1 and o_mN_rdt SHALL equal i_s_rdt in that same cycle (zero added latency), and the FSM SHALL enter DONE.
REQ-019 o_mN_ack SHALL never be asserted for a master not holding the grant; a non-granted master's o_mN_rdt SHALL be 0.
REQ-020 A wait counter SHALL clear on entry to BUSN and increment each BUSN cycle without i_s_ack.
REQ-021 When the counter equals TIMEOUT_CYCLES without i_s_ack, the block SHALL assert o_mN_ack with o_mN_rdt = ERR_DATA and o_timeout = 1 for one cycle, then enter DONE.
REQ-022 If i_s_ack and the timeout coincide, the block SHALL treat it as a normal ack with o_timeout = 0.
REQ-023 DONE SHALL last exactly one cycle with o_s_cyc = 0, ignoring both requests, then return to IDLE.
REQ-024 If the granted master drops i_mN_cyc before ack, the block SHALL abandon the transfer, without acking, and enter DONE on the next edge.
REQ-025 Minimum cost per transfer SHALL be 1 cycle grant + slave latency + 1 cycle DONE.

Reset
REQ-026 Asserting i_rst_n low SHALL immediately force state IDLE, pointer = master 0, counter = 0, and all outputs 0, including mid-transfer.
REQ-027 After deassertion, the first grant SHALL occur no earlier than the first rising edge with i_rst_n high.

Structure
REQ-028 State encoding, TIMEOUT_CYCLES default and ERR_DATA default SHALL live in a shared package rocketcpu_pkg.
REQ-029 The block SHALL be flat except for one sub-module, rocketcpu_rr_pick, a two-way round-robin selector.

Verification
REQ-030 Master 0 writes 32'h0000_1234 to 32'h1000_0004 with a slave that acks 2 cycles after cyc -> o_s_cyc high for 2 cycles; o_m0_ack pulses once; o_m1_ack stays 0.
REQ-031 Both masters assert cyc together from reset, reading 32'h1000_0000 and 32'h1000_0008 -> master 0 served first, master 1 next; each sees its own rdt; one DONE cycle between transfers.
REQ-032 Both masters hold cyc continuously for 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-033 Slave never acks, TIMEOUT_CYCLES=4 -> after 4 wait cycles o_m1_ack=1, o_m1_rdt=32'hDEAD_BEEF, o_timeout=1 for one cycle, then DONE, then IDLE.
REQ-034 i_rst_n pulsed low during BUS1 -> o_s_cyc and o_m1_ack fall to 0 asynchronously; after release, a pending master 0 request is granted first.
REQ-035 Slave ack lands on the exact timeout cycle -> normal ack with slave data; o_timeout stays 0.
